// File: rtl/control_unit_pkg.sv
// Shared encodings for the CPU control unit: registers, ALU ops, conditions,
// instruction layout, status flags and FSM states.
package control_unit_pkg;

  typedef enum logic [3:0] {
    R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, SP, LR, PC
  } reg_e;

  typedef enum logic [3:0] {
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC,
    ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROR, ALU_MOV, ALU_CMP, ALU_TST, ALU_NEG
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_NONE = 4'd0,
    COND_EQ   = 4'd1,
    COND_NE   = 4'd2,
    COND_LT   = 4'd3,
    COND_GE   = 4'd4,
    COND_CS   = 4'd5,
    COND_CC   = 4'd6
  } cond_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } status_t;

  typedef struct packed {
    logic immediate;
    logic reverse;
    logic load;
    logic set_status;
  } alu_flags_t;

  typedef struct packed {
    alu_flags_t flags;
    reg_e       reg_a;
    reg_e       reg_b;
    logic [3:0] rsvd;
    reg_e       reg_c;
  } alu_params_t;

  typedef union packed {
    alu_params_t alu_op;
    logic [19:0] raw;
  } params_t;

  typedef struct packed {
    cond_e      condition;
    logic [7:0] instruction;
    params_t    params;
  } ir_t;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_FETCH,
    ST_EXECUTE
  } state_e;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned COUNT_W  = 8;
  localparam logic [7:0]  OP_ALU_LIMIT = 8'h10;
  localparam logic [7:0]  OP_LD    = 8'h10;
  localparam logic [7:0]  OP_ST    = 8'h11;
  localparam logic [7:0]  OP_PUSH  = 8'h12;
  localparam logic [7:0]  OP_POP   = 8'h13;
  localparam logic [7:0]  OP_HALT  = 8'h1F;
  localparam logic [DATA_W-1:0] IMM_MASK = 32'h0000_00FF;

  // Condition codes not listed evaluate false so the instruction is skipped.
  function automatic logic cond_met(input cond_e c, input status_t s);
    case (c)
      COND_NONE: cond_met = 1'b1;
      COND_EQ:   cond_met = s.zero;
      COND_NE:   cond_met = !s.zero;
      COND_LT:   cond_met = s.negative != s.overflow;
      COND_GE:   cond_met = s.negative == s.overflow;
      COND_CS:   cond_met = s.carry;
      COND_CC:   cond_met = !s.carry;
      default:   cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// CPU control unit: STOP/FETCH/EXECUTE sequencer with combinational strobe
// decode from the current state and instruction register.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  ir_t                 ir,
  input  status_t             status,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [DATA_W-1:0]   a_reg_mask,
  output logic [DATA_W-1:0]   b_reg_mask,
  output logic                oe_a_reg_file,
  output logic                oe_b_reg_file,
  output logic                ld_reg_file,
  output reg_e                sel_a_reg_file,
  output reg_e                sel_b_reg_file,
  output reg_e                sel_in_reg_file,
  output logic [COUNT_W-1:0]  count_a_reg_file,
  output logic [COUNT_W-1:0]  count_b_reg_file,
  output logic                pre_count_a_reg_file,
  output logic                pre_count_b_reg_file,
  output logic                post_count_a_reg_file,
  output logic                post_count_b_reg_file,
  output logic                oe_a_ir,
  output logic                oe_b_ir,
  output logic                ld_ir,
  output logic                ld_status,
  output logic                oe_mdr,
  output logic                ld_mdr,
  output logic                oe_mar,
  output logic                ld_mar,
  output logic                oe_alu,
  output alu_op_e             alu_op
);

  state_e      state_q, state_d;
  alu_params_t p;
  logic        cond_ok;
  logic        unused_rsvd;

  assign p           = ir.params.alu_op;
  assign cond_ok     = cond_met(ir.condition, status);
  assign unused_rsvd = ^p.rsvd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    mem_rd                = 1'b0;
    mem_wr                = 1'b0;
    a_reg_mask            = '0;
    b_reg_mask            = '0;
    oe_a_reg_file         = 1'b0;
    oe_b_reg_file         = 1'b0;
    ld_reg_file           = 1'b0;
    sel_a_reg_file        = R0;
    sel_b_reg_file        = R0;
    sel_in_reg_file       = R0;
    count_a_reg_file      = '0;
    count_b_reg_file      = '0;
    pre_count_a_reg_file  = 1'b0;
    pre_count_b_reg_file  = 1'b0;
    post_count_a_reg_file = 1'b0;
    post_count_b_reg_file = 1'b0;
    oe_a_ir               = 1'b0;
    oe_b_ir               = 1'b0;
    ld_ir                 = 1'b0;
    ld_status             = 1'b0;
    oe_mdr                = 1'b0;
    ld_mdr                = 1'b0;
    oe_mar                = 1'b0;
    ld_mar                = 1'b0;
    oe_alu                = 1'b0;
    alu_op                = ALU_AND;

    case (state_q)
      ST_STOP: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        sel_b_reg_file        = PC;
        oe_b_reg_file         = 1'b1;
        mem_rd                = 1'b1;
        ld_ir                 = 1'b1;
        count_b_reg_file      = COUNT_W'(1);
        post_count_b_reg_file = 1'b1;
        state_d               = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (cond_ok) begin
          if (ir.instruction < OP_ALU_LIMIT) begin
            // Reverse puts the second operand (reg_c or immediate) on bus A.
            alu_op          = alu_op_e'(ir.instruction[3:0]);
            oe_alu          = 1'b1;
            sel_in_reg_file = p.reg_a;
            ld_reg_file     = p.flags.load;
            ld_status       = p.flags.set_status;
            if (!p.flags.reverse) begin
              sel_a_reg_file = p.reg_b;
              oe_a_reg_file  = 1'b1;
              if (p.flags.immediate) begin
                oe_b_ir    = 1'b1;
                b_reg_mask = IMM_MASK;
              end else begin
                sel_b_reg_file = p.reg_c;
                oe_b_reg_file  = 1'b1;
              end
            end else begin
              sel_b_reg_file = p.reg_b;
              oe_b_reg_file  = 1'b1;
              if (p.flags.immediate) begin
                oe_a_ir    = 1'b1;
                a_reg_mask = IMM_MASK;
              end else begin
                sel_a_reg_file = p.reg_c;
                oe_a_reg_file  = 1'b1;
              end
            end
          end else begin
            case (ir.instruction)
              OP_LD: begin
                sel_b_reg_file  = p.reg_b;
                oe_b_reg_file   = 1'b1;
                mem_rd          = 1'b1;
                sel_in_reg_file = p.reg_a;
                ld_reg_file     = 1'b1;
              end
              OP_ST: begin
                sel_b_reg_file = p.reg_b;
                oe_b_reg_file  = 1'b1;
                sel_a_reg_file = p.reg_a;
                oe_a_reg_file  = 1'b1;
                mem_wr         = 1'b1;
              end
              OP_PUSH: begin
                sel_b_reg_file       = SP;
                oe_b_reg_file        = 1'b1;
                count_b_reg_file     = 8'hFF;
                pre_count_b_reg_file = 1'b1;
                sel_a_reg_file       = p.reg_a;
                oe_a_reg_file        = 1'b1;
                mem_wr               = 1'b1;
              end
              OP_POP: begin
                sel_b_reg_file        = SP;
                oe_b_reg_file         = 1'b1;
                count_b_reg_file      = COUNT_W'(1);
                post_count_b_reg_file = 1'b1;
                mem_rd                = 1'b1;
                sel_in_reg_file       = p.reg_a;
                ld_reg_file           = 1'b1;
              end
              OP_HALT: state_d = ST_STOP;
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;
  import control_unit_pkg::*;

  logic clk, rst, start;
  ir_t ir;
  status_t status;
  logic mem_rd, mem_wr;
  logic [31:0] a_reg_mask, b_reg_mask;
  logic oe_a_reg_file, oe_b_reg_file, ld_reg_file;
  reg_e sel_a_reg_file, sel_b_reg_file, sel_in_reg_file;
  logic [7:0] count_a_reg_file, count_b_reg_file;
  logic pre_count_a_reg_file, pre_count_b_reg_file;
  logic post_count_a_reg_file, post_count_b_reg_file;
  logic oe_a_ir, oe_b_ir, ld_ir, ld_status, oe_mdr, ld_mdr, oe_mar, ld_mar, oe_alu;
  alu_op_e alu_op;
  logic [113:0] all_out;

  int checks = 0;
  int errors = 0;

  control_unit cu (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .status(status),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .a_reg_mask(a_reg_mask), .b_reg_mask(b_reg_mask),
    .oe_a_reg_file(oe_a_reg_file), .oe_b_reg_file(oe_b_reg_file), .ld_reg_file(ld_reg_file),
    .sel_a_reg_file(sel_a_reg_file), .sel_b_reg_file(sel_b_reg_file),
    .sel_in_reg_file(sel_in_reg_file),
    .count_a_reg_file(count_a_reg_file), .count_b_reg_file(count_b_reg_file),
    .pre_count_a_reg_file(pre_count_a_reg_file), .pre_count_b_reg_file(pre_count_b_reg_file),
    .post_count_a_reg_file(post_count_a_reg_file), .post_count_b_reg_file(post_count_b_reg_file),
    .oe_a_ir(oe_a_ir), .oe_b_ir(oe_b_ir), .ld_ir(ld_ir), .ld_status(ld_status),
    .oe_mdr(oe_mdr), .ld_mdr(ld_mdr), .oe_mar(oe_mar), .ld_mar(ld_mar),
    .oe_alu(oe_alu), .alu_op(alu_op)
  );

  assign all_out = {mem_rd, mem_wr, a_reg_mask, b_reg_mask, oe_a_reg_file, oe_b_reg_file,
                    ld_reg_file, sel_a_reg_file, sel_b_reg_file, sel_in_reg_file,
                    count_a_reg_file, count_b_reg_file, pre_count_a_reg_file,
                    pre_count_b_reg_file, post_count_a_reg_file, post_count_b_reg_file,
                    oe_a_ir, oe_b_ir, ld_ir, ld_status, oe_mdr, ld_mdr, oe_mar, ld_mar,
                    oe_alu, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ir = ir_t'(32'h0); status = status_t'(4'h0);
    repeat (2) tick();
    checks++;
    if (all_out !== 114'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_stop_hold();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (all_out !== 114'h0) begin
        errors++; $display("FAIL stop_hold[%0d]: got %h want 0", i, all_out);
      end
    end
  endtask

  task automatic test_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (sel_b_reg_file !== PC || oe_b_reg_file !== 1'b1 || mem_rd !== 1'b1 ||
        ld_ir !== 1'b1 || count_b_reg_file !== 8'h01 || post_count_b_reg_file !== 1'b1) begin
      errors++;
      $display("FAIL fetch_strobes: sel_b=%0d oe_b=%b rd=%b ld_ir=%b cnt=%h post=%b want 15 1 1 1 01 1",
               sel_b_reg_file, oe_b_reg_file, mem_rd, ld_ir, count_b_reg_file, post_count_b_reg_file);
    end
    checks++;
    if (oe_a_reg_file !== 1'b0 || ld_reg_file !== 1'b0 || mem_wr !== 1'b0 || oe_alu !== 1'b0) begin
      errors++;
      $display("FAIL fetch_quiet: oe_a=%b ld_rf=%b wr=%b oe_alu=%b want 0 0 0 0",
               oe_a_reg_file, ld_reg_file, mem_wr, oe_alu);
    end
  endtask

  // AND R0 <- R1, R2, load=1
  task automatic test_alu_reg();
    ir = ir_t'(32'h0002_0102);
    tick();
    checks++;
    if (sel_a_reg_file !== R1 || oe_a_reg_file !== 1'b1 || sel_b_reg_file !== R2 ||
        oe_b_reg_file !== 1'b1 || alu_op !== ALU_AND || oe_alu !== 1'b1 ||
        sel_in_reg_file !== R0 || ld_reg_file !== 1'b1 || ld_status !== 1'b0 ||
        oe_b_ir !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL alu_reg: a=%0d/%b b=%0d/%b op=%0d alu=%b in=%0d ld=%b st=%b bir=%b rd=%b want 1/1 2/1 0 1 0 1 0 0 0",
               sel_a_reg_file, oe_a_reg_file, sel_b_reg_file, oe_b_reg_file, alu_op, oe_alu,
               sel_in_reg_file, ld_reg_file, ld_status, oe_b_ir, mem_rd);
    end
    tick();
    checks++;
    if (ld_ir !== 1'b1 || sel_b_reg_file !== PC) begin
      errors++; $display("FAIL alu_reg_return: ld_ir=%b sel_b=%0d want 1 15", ld_ir, sel_b_reg_file);
    end
  endtask

  // ADD R3 <- R4 + imm 0x5A, load=1, set_status=1
  task automatic test_alu_imm();
    ir = ir_t'(32'h004B_345A);
    tick();
    checks++;
    if (sel_a_reg_file !== R4 || oe_a_reg_file !== 1'b1 || oe_b_ir !== 1'b1 ||
        b_reg_mask !== 32'h0000_00FF || oe_b_reg_file !== 1'b0 || ld_status !== 1'b1 ||
        ld_reg_file !== 1'b1 || alu_op !== ALU_ADD || sel_in_reg_file !== R3 ||
        a_reg_mask !== 32'h0) begin
      errors++;
      $display("FAIL alu_imm: a=%0d/%b bir=%b bm=%h oe_b=%b st=%b ld=%b op=%0d in=%0d am=%h",
               sel_a_reg_file, oe_a_reg_file, oe_b_ir, b_reg_mask, oe_b_reg_file, ld_status,
               ld_reg_file, alu_op, sel_in_reg_file, a_reg_mask);
    end
    tick();
  endtask

  // SUB R5 <- imm - R6 (reverse + immediate), load=1
  task automatic test_alu_reverse();
    ir = ir_t'(32'h006E_5610);
    tick();
    checks++;
    if (oe_a_ir !== 1'b1 || a_reg_mask !== 32'h0000_00FF || oe_a_reg_file !== 1'b0 ||
        sel_b_reg_file !== R6 || oe_b_reg_file !== 1'b1 || b_reg_mask !== 32'h0 ||
        oe_b_ir !== 1'b0 || alu_op !== ALU_SUB || ld_status !== 1'b0) begin
      errors++;
      $display("FAIL alu_reverse: air=%b am=%h oe_a=%b b=%0d/%b bm=%h bir=%b op=%0d st=%b",
               oe_a_ir, a_reg_mask, oe_a_reg_file, sel_b_reg_file, oe_b_reg_file, b_reg_mask,
               oe_b_ir, alu_op, ld_status);
    end
    tick();
  endtask

  // AND with cond EQ: skipped when zero=0, executed when zero=1
  task automatic test_cond();
    ir = ir_t'(32'h1002_0102);
    status = status_t'(4'b0000);
    tick();
    checks++;
    if (all_out !== 114'h0) begin
      errors++; $display("FAIL cond_false: got %h want 0", all_out);
    end
    tick();
    checks++;
    if (ld_ir !== 1'b1) begin
      errors++; $display("FAIL cond_false_return: ld_ir=%b want 1", ld_ir);
    end
    status = status_t'(4'b0100);
    tick();
    checks++;
    if (ld_reg_file !== 1'b1 || oe_alu !== 1'b1) begin
      errors++; $display("FAIL cond_true: ld=%b alu=%b want 1 1", ld_reg_file, oe_alu);
    end
    status = status_t'(4'h0);
    tick();
  endtask

  task automatic test_mem_ops();
    ir = ir_t'(32'h0100_7800);  // LD R7 <- [R8]
    tick();
    checks++;
    if (sel_b_reg_file !== R8 || oe_b_reg_file !== 1'b1 || mem_rd !== 1'b1 ||
        sel_in_reg_file !== R7 || ld_reg_file !== 1'b1 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL ld: b=%0d/%b rd=%b in=%0d ld=%b wr=%b want 8/1 1 7 1 0",
               sel_b_reg_file, oe_b_reg_file, mem_rd, sel_in_reg_file, ld_reg_file, mem_wr);
    end
    tick();
    ir = ir_t'(32'h0120_9000);  // PUSH R9
    tick();
    checks++;
    if (sel_b_reg_file !== SP || oe_b_reg_file !== 1'b1 || count_b_reg_file !== 8'hFF ||
        pre_count_b_reg_file !== 1'b1 || post_count_b_reg_file !== 1'b0 ||
        sel_a_reg_file !== R9 || oe_a_reg_file !== 1'b1 || mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL push: b=%0d/%b cnt=%h pre=%b post=%b a=%0d/%b wr=%b rd=%b want 13/1 ff 1 0 9/1 1 0",
               sel_b_reg_file, oe_b_reg_file, count_b_reg_file, pre_count_b_reg_file,
               post_count_b_reg_file, sel_a_reg_file, oe_a_reg_file, mem_wr, mem_rd);
    end
    tick();
  endtask

  task automatic test_halt();
    ir = ir_t'(32'h01F0_0000);
    tick();
    checks++;
    if (all_out !== 114'h0) begin
      errors++; $display("FAIL halt_exec: got %h want 0", all_out);
    end
    tick();
    checks++;
    if (all_out !== 114'h0) begin
      errors++; $display("FAIL halt_stop: got %h want 0", all_out);
    end
  endtask

  task automatic test_rst_mid();
    ir = ir_t'(32'h0002_0102);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (oe_alu !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: oe_alu=%b want 1", oe_alu);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 114'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h want 0", all_out);
    end
    #2 rst = 1'b0;
    tick();
    checks++;
    if (all_out !== 114'h0) begin
      errors++; $display("FAIL rst_mid_stop: got %h want 0", all_out);
    end
  endtask

  initial begin
    test_reset();
    test_stop_hold();
    test_fetch();
    test_alu_reg();
    test_alu_imm();
    test_alu_reverse();
    test_cond();
    test_mem_ops();
    test_halt();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
